// File: rtl/mem_types_pkg.sv
// Shared memory-access types for the pipeline MEM stage and mem_access_unit.
// The misalignment helpers back the optional MISALIGN_TRAP_EN build.
package mem_types_pkg;

   typedef enum logic {
      MEM_READ  = 1'b0,
      MEM_WRITE = 1'b1
   } mem_rw_t;

   typedef enum logic [2:0] {
      BYTE   = 3'd0,
      HALF   = 3'd1,
      WORD   = 3'd2,
      BYTE_U = 3'd3,
      HALF_U = 3'd4
   } rw_type_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2,
      RESP  = 2'd3
   } mau_state_t;

   // Access size in bytes; 0 marks an illegal type code.
   function automatic logic [2:0] size_of(input rw_type_t t);
      logic [2:0] sz;
      case (t)
         BYTE, BYTE_U: sz = 3'd1;
         HALF, HALF_U: sz = 3'd2;
         WORD:         sz = 3'd4;
         default:      sz = 3'd0;
      endcase
      return sz;
   endfunction

   function automatic logic needs_split(input logic [2:0] t, input logic [1:0] off);
      return ({2'b00, off} + {1'b0, size_of(rw_type_t'(t))}) > 4'd4;
   endfunction

   function automatic logic misaligned(input logic [2:0] t, input logic [1:0] off);
      logic [2:0] sz;
      sz = size_of(rw_type_t'(t));
      return ((sz == 3'd2) && off[0]) || ((sz == 3'd4) && (off != 2'b00));
   endfunction

endpackage

// File: rtl/lane_align.sv
// Combinational byte-lane steering for stores and load extraction/extension.
// Store data and mask span two words so the upper half feeds a second beat.
module lane_align
   import mem_types_pkg::*;
(
   input  logic [2:0]  rw_type,
   input  logic [1:0]  offset,
   input  logic [63:0] rdata64,
   input  logic [31:0] wdata,
   output logic [63:0] st_data,
   output logic [7:0]  st_mask,
   output logic [31:0] ld_data
);

   logic [7:0]  base_mask;
   logic [31:0] shifted;

   // Steer store lanes and extract/extend the addressed load bytes.
   always_comb begin
      case (size_of(rw_type_t'(rw_type)))
         3'd1:    base_mask = 8'h01;
         3'd2:    base_mask = 8'h03;
         3'd4:    base_mask = 8'h0F;
         default: base_mask = 8'h00;
      endcase
      st_data = {32'd0, wdata} << {offset, 3'b000};
      st_mask = base_mask << offset;
      shifted = 32'(rdata64 >> {offset, 3'b000});
      case (rw_type)
         BYTE:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
         BYTE_U:  ld_data = {24'd0, shifted[7:0]};
         HALF:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
         HALF_U:  ld_data = {16'd0, shifted[15:0]};
         WORD:    ld_data = shifted;
         default: ld_data = 32'd0;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Sequential load/store unit: one request per handshake, 1-2 word beats on a req/ack port.
// Define MISALIGN_TRAP_EN to reject misaligned accesses instead of splitting them.
module mem_access_unit
   import mem_types_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_rw,
   input  logic [2:0]            req_type,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  rsp_valid,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-3:0] mem_addr,
   output logic [3:0]            mem_we,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata,
   input  logic                  mem_ack
);

   localparam logic [ADDR_WIDTH-3:0] WORD_INC = {{(ADDR_WIDTH-3){1'b0}}, 1'b1};

   if (DATA_WIDTH != 32) begin : g_dw_check
      $error("mem_access_unit: DATA_WIDTH must be 32");
   end

   mau_state_t            state_q, state_d;
   logic                  rw_q, rw_d;
   logic [2:0]            type_q, type_d;
   logic [1:0]            off_q, off_d;
   logic [ADDR_WIDTH-3:0] word_q, word_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  err_q, err_d;
   logic                  split_q, split_d;
   logic [31:0]           lo_q, lo_d, hi_q, hi_d;
   logic                  req_ready_q, req_ready_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_err_q, rsp_err_d;
   logic [31:0]           rsp_rdata_q, rsp_rdata_d;
   logic                  mem_req_q, mem_req_d;
   logic [ADDR_WIDTH-3:0] mem_addr_q, mem_addr_d;
   logic [3:0]            mem_we_q, mem_we_d;
   logic [31:0]           mem_wdata_q, mem_wdata_d;

   logic        req_illegal_s, req_split_s;
   logic [2:0]  st_type_s;
   logic [1:0]  st_off_s;
   logic [31:0] st_wdata_s, ld_data_s, st_unused_ld, ld_unused_wdata;
   logic [63:0] st_data_s, ld_unused_data;
   logic [7:0]  st_mask_s, ld_unused_mask;

   // While idle the store path steers the incoming request so beat0 can launch on accept.
   assign st_type_s       = (state_q == IDLE) ? req_type  : type_q;
   assign st_off_s        = (state_q == IDLE) ? req_addr[1:0] : off_q;
   assign st_wdata_s      = (state_q == IDLE) ? req_wdata : wdata_q;
   assign ld_unused_wdata = 32'd0;

   lane_align u_store_align (
      .rw_type (st_type_s),
      .offset  (st_off_s),
      .rdata64 (64'd0),
      .wdata   (st_wdata_s),
      .st_data (st_data_s),
      .st_mask (st_mask_s),
      .ld_data (st_unused_ld)
   );

   lane_align u_load_align (
      .rw_type (type_q),
      .offset  (off_q),
      .rdata64 ({hi_q, lo_q}),
      .wdata   (ld_unused_wdata),
      .st_data (ld_unused_data),
      .st_mask (ld_unused_mask),
      .ld_data (ld_data_s)
   );

   // Classify the incoming request: illegal codes, unsigned stores, optional misalign trap.
   always_comb begin
`ifdef MISALIGN_TRAP_EN
      req_illegal_s = (req_type > 3'd4)
                   || ((req_rw == MEM_WRITE) && ((req_type == BYTE_U) || (req_type == HALF_U)))
                   || misaligned(req_type, req_addr[1:0]);
      req_split_s   = 1'b0;
`else
      req_illegal_s = (req_type > 3'd4)
                   || ((req_rw == MEM_WRITE) && ((req_type == BYTE_U) || (req_type == HALF_U)));
      req_split_s   = needs_split(req_type, req_addr[1:0]);
`endif
   end

   // Next-state and next-output logic for the access FSM.
   always_comb begin
      state_d     = state_q;
      rw_d        = rw_q;
      type_d      = type_q;
      off_d       = off_q;
      word_d      = word_q;
      wdata_d     = wdata_q;
      err_d       = err_q;
      split_d     = split_q;
      lo_d        = lo_q;
      hi_d        = hi_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      mem_req_d   = mem_req_q;
      mem_addr_d  = mem_addr_q;
      mem_we_d    = mem_we_q;
      mem_wdata_d = mem_wdata_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               rw_d        = req_rw;
               type_d      = req_type;
               off_d       = req_addr[1:0];
               word_d      = req_addr[ADDR_WIDTH-1:2];
               wdata_d     = req_wdata;
               err_d       = req_illegal_s;
               split_d     = req_split_s;
               lo_d        = 32'd0;
               hi_d        = 32'd0;
               req_ready_d = 1'b0;
               if (req_illegal_s) begin
                  state_d = RESP;
               end else begin
                  state_d     = BEAT0;
                  mem_req_d   = 1'b1;
                  mem_addr_d  = req_addr[ADDR_WIDTH-1:2];
                  mem_we_d    = (req_rw == MEM_WRITE) ? st_mask_s[3:0] : 4'b0000;
                  mem_wdata_d = (req_rw == MEM_WRITE) ? st_data_s[31:0] : 32'd0;
               end
            end else begin
               req_ready_d = 1'b1;
            end
         end
         BEAT0: begin
            if (mem_ack) begin
               lo_d      = mem_rdata;
               mem_req_d = 1'b0;
               if (split_q) begin
                  // Beat1 signals are set up during the mandatory idle gap cycle.
                  state_d     = BEAT1;
                  mem_addr_d  = word_q + WORD_INC;
                  mem_we_d    = (rw_q == MEM_WRITE) ? st_mask_s[7:4] : 4'b0000;
                  mem_wdata_d = (rw_q == MEM_WRITE) ? st_data_s[63:32] : 32'd0;
               end else begin
                  state_d  = RESP;
                  mem_we_d = 4'b0000;
               end
            end else begin
               state_d = BEAT0;
            end
         end
`ifndef MISALIGN_TRAP_EN
         BEAT1: begin
            if (!mem_req_q) begin
               mem_req_d = 1'b1;
            end else if (mem_ack) begin
               hi_d      = mem_rdata;
               mem_req_d = 1'b0;
               mem_we_d  = 4'b0000;
               state_d   = RESP;
            end else begin
               state_d = BEAT1;
            end
         end
`endif
         RESP: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_err_d   = err_q;
            rsp_rdata_d = (err_q || (rw_q == MEM_WRITE)) ? 32'd0 : ld_data_s;
         end
         default: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
            mem_req_d   = 1'b0;
            mem_we_d    = 4'b0000;
         end
      endcase
   end

   // Access FSM state, request context, beat buffers and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rw_q        <= 1'b0;
         type_q      <= 3'd0;
         off_q       <= 2'd0;
         word_q      <= '0;
         wdata_q     <= 32'd0;
         err_q       <= 1'b0;
         split_q     <= 1'b0;
         lo_q        <= 32'd0;
         hi_q        <= 32'd0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 32'd0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_we_q    <= 4'b0000;
         mem_wdata_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         rw_q        <= rw_d;
         type_q      <= type_d;
         off_q       <= off_d;
         word_q      <= word_d;
         wdata_q     <= wdata_d;
         err_q       <= err_d;
         split_q     <= split_d;
         lo_q        <= lo_d;
         hi_q        <= hi_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         mem_we_q    <= mem_we_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_addr  = mem_addr_q;
   assign mem_we    = mem_we_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-addressed reference memory, ack-delay responder, random + directed requests.
module tb_mem_access_unit;
   import mem_types_pkg::*;

   logic        clk = 1'b0;
   logic        rst, req_valid, req_ready, req_rw;
   logic [2:0]  req_type;
   logic [11:0] req_addr;
   logic [31:0] req_wdata, rsp_rdata, mem_wdata, mem_rdata;
   logic        rsp_valid, rsp_err, mem_req, mem_ack;
   logic [9:0]  mem_addr;
   logic [3:0]  mem_we;

   always #5 clk = ~clk;

   mem_access_unit #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
      .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   int passed = 0, total = 0, failed = 0;
   int ack_delay = 0, wait_cnt = 0, stable_err = 0, gap_err = 0;
   logic [31:0] mem_words [1024];
   logic [7:0]  ref_bytes [4096];
   logic [9:0]  beat_addr_q [$];
   logic [3:0]  beat_we_q [$];
   logic [31:0] beat_wd_q [$];
   logic [9:0]  cur_addr;
   logic [3:0]  cur_we;
   logic [31:0] cur_wd, last_rd, tmp;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int sz(input logic [2:0] t);
      case (t)
         3'd0, 3'd3: return 1;
         3'd1, 3'd4: return 2;
         3'd2:       return 4;
         default:    return 0;
      endcase
   endfunction

   task automatic poke_word(input int w, input logic [31:0] v);
      mem_words[w] = v;
      for (int b = 0; b < 4; b++) ref_bytes[4*w+b] = v[8*b +: 8];
   endtask

   // Memory responder: ack after ack_delay wait cycles, record beats, watch stability and gaps.
   initial begin
      mem_ack = 1'b0;
      mem_rdata = 32'd0;
      forever begin
         @(negedge clk);
         if (mem_ack) begin
            mem_ack = 1'b0;
            if (mem_req) gap_err++;
            wait_cnt = 0;
         end else if (mem_req) begin
            if (wait_cnt == 0) begin
               cur_addr = mem_addr; cur_we = mem_we; cur_wd = mem_wdata;
               beat_addr_q.push_back(mem_addr);
               beat_we_q.push_back(mem_we);
               beat_wd_q.push_back(mem_wdata);
            end else if (mem_addr !== cur_addr || mem_we !== cur_we || mem_wdata !== cur_wd) begin
               stable_err++;
            end
            if (wait_cnt >= ack_delay) begin
               mem_ack = 1'b1;
               mem_rdata = mem_words[mem_addr];
               for (int b = 0; b < 4; b++)
                  if (mem_we[b]) mem_words[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   task automatic run_req(input logic rw, input logic [2:0] ty, input logic [11:0] addr,
                          input logic [31:0] wd, input int dly, input bit mid, input string tag);
      int size, a, n, exp_beats, exp_lat, busy_err;
      bit ill, got;
      logic [31:0] exp_rd;
      size = sz(ty);
      a = int'(addr);
      ill = (ty > 3'd4) || (rw && (ty == 3'd3 || ty == 3'd4));
`ifdef MISALIGN_TRAP_EN
      ill = ill || (size > 1 && (a % size) != 0);
`endif
      exp_beats = ill ? 0 : (((a % 4) + size > 4) ? 2 : 1);
      exp_lat   = ill ? 1 : ((exp_beats == 1) ? dly + 2 : 2*dly + 4);
      exp_rd = 32'd0;
      if (!ill && !rw) begin
         for (int i = 0; i < size; i++) exp_rd |= {24'd0, ref_bytes[(a+i) % 4096]} << (8*i);
         if (ty == 3'd0 && exp_rd[7])  exp_rd |= 32'hFFFF_FF00;
         if (ty == 3'd1 && exp_rd[15]) exp_rd |= 32'hFFFF_0000;
      end
      if (!ill && rw)
         for (int i = 0; i < size; i++) ref_bytes[(a+i) % 4096] = wd[8*i +: 8];
      ack_delay = dly;
      beat_addr_q.delete(); beat_we_q.delete(); beat_wd_q.delete();
      busy_err = 0;
      @(negedge clk);
      check({tag, ".ready"}, {63'd0, req_ready}, 64'd1);
      req_valid = 1'b1; req_rw = rw; req_type = ty; req_addr = addr; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0; req_addr = 12'($urandom); req_wdata = $urandom;
      n = 0; got = 0;
      while (!got && n < 300) begin
         @(negedge clk);
         n++;
         if (rsp_valid) begin
            got = 1;
            last_rd = rsp_rdata;
            check({tag, ".err"}, {63'd0, rsp_err}, {63'd0, ill});
         end else begin
            if (req_ready) busy_err++;
            req_valid = (mid && n == 2) ? 1'b1 : 1'b0;
            req_type = 3'd2;
         end
      end
      req_valid = 1'b0;
      check({tag, ".done"}, {63'd0, got}, 64'd1);
      check({tag, ".lat"}, 64'(n - 1), 64'(exp_lat));
      check({tag, ".rdata"}, {32'd0, last_rd}, {32'd0, exp_rd});
      check({tag, ".beats"}, 64'(beat_addr_q.size()), 64'(exp_beats));
      check({tag, ".busy"}, 64'(busy_err), 64'd0);
      @(negedge clk);
      check({tag, ".pulse"}, {63'd0, rsp_valid}, 64'd0);
   endtask

   initial begin
      int bad;
      rst = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_type = 3'd0; req_addr = 12'd0; req_wdata = 32'd0;
      for (int w = 0; w < 1024; w++) poke_word(w, $urandom);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst.ready", {63'd0, req_ready}, 64'd1);
      check("rst.valid", {63'd0, rsp_valid}, 64'd0);
      check("rst.err", {63'd0, rsp_err}, 64'd0);
      check("rst.rdata", {32'd0, rsp_rdata}, 64'd0);
      check("rst.mreq", {63'd0, mem_req}, 64'd0);
      check("rst.mwe", {60'd0, mem_we}, 64'd0);
      check("rst.maddr", {54'd0, mem_addr}, 64'd0);
      check("rst.mwdata", {32'd0, mem_wdata}, 64'd0);
      rst = 1'b0;

      run_req(1'b1, 3'd2, 12'h010, 32'hDEAD_BEEF, 0, 0, "w_word");
      check("w_word.addr", {54'd0, beat_addr_q[0]}, 64'h004);
      check("w_word.we", {60'd0, beat_we_q[0]}, 64'hF);
      check("w_word.wd", {32'd0, beat_wd_q[0]}, 64'hDEAD_BEEF);

      poke_word(4, 32'h80FF_FF00);
      run_req(1'b0, 3'd0, 12'h013, 32'd0, 0, 0, "r_byte");
      check("r_byte.val", {32'd0, last_rd}, 64'hFFFF_FF80);
      run_req(1'b0, 3'd3, 12'h013, 32'd0, 0, 0, "r_byteu");
      check("r_byteu.val", {32'd0, last_rd}, 64'h0000_0080);

`ifndef MISALIGN_TRAP_EN
      run_req(1'b1, 3'd1, 12'h007, 32'h0000_A55A, 0, 0, "w_half7");
      check("w_half7.a0", {54'd0, beat_addr_q[0]}, 64'h001);
      check("w_half7.we0", {60'd0, beat_we_q[0]}, 64'h8);
      tmp = beat_wd_q[0];
      check("w_half7.wd0", {56'd0, tmp[31:24]}, 64'h5A);
      check("w_half7.a1", {54'd0, beat_addr_q[1]}, 64'h002);
      check("w_half7.we1", {60'd0, beat_we_q[1]}, 64'h1);
      tmp = beat_wd_q[1];
      check("w_half7.wd1", {56'd0, tmp[7:0]}, 64'hA5);

      poke_word(10'h3FF, 32'h3344_ABCD);
      poke_word(0, 32'h9988_1122);
      run_req(1'b0, 3'd2, 12'hFFE, 32'd0, 0, 0, "r_wrap");
      check("r_wrap.a1", {54'd0, beat_addr_q[1]}, 64'h000);
      check("r_wrap.val", {32'd0, last_rd}, 64'h1122_3344);
`else
      run_req(1'b0, 3'd2, 12'h001, 32'd0, 0, 0, "r_trap");
      check("r_trap.val", {32'd0, last_rd}, 64'd0);
`endif

      stable_err = 0;
      run_req(1'b0, 3'd2, 12'h020, 32'd0, 5, 1, "r_delay");
      check("r_delay.stable", 64'(stable_err), 64'd0);
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (mem_req || rsp_valid) bad++;
      end
      check("r_delay.noaccept", 64'(bad), 64'd0);

      run_req(1'b1, 3'd3, 12'h040, 32'h0000_0055, 0, 0, "w_byteu");

      ack_delay = 10;
      @(negedge clk);
      req_valid = 1'b1; req_rw = 1'b0; req_type = 3'd2; req_addr = 12'h080;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      check("rst_beat.pre", {63'd0, mem_req}, 64'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst_beat.mreq", {63'd0, mem_req}, 64'd0);
      check("rst_beat.ready", {63'd0, req_ready}, 64'd1);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 60; i++) begin
         logic [11:0] ra;
         ra = (i % 10 == 0) ? 12'hFFC + 12'($urandom_range(0, 3)) : 12'($urandom_range(0, 4095));
         run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom,
                 $urandom_range(0, 3), 0, "rand");
      end

      check("gap", 64'(gap_err), 64'd0);
      bad = 0;
      for (int w = 0; w < 1024; w++)
         if (mem_words[w] !== {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]})
            bad++;
      check("memimage", 64'(bad), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
